// File: rtl/im_pkg.sv
// Shared constants and types for the instruction-memory responder.
// IM_PARITY_WORD_W is the stored word width used when IM_PARITY_EN is defined.
package im_pkg;

  localparam logic [31:0] IM_NOP           = 32'h0000_0013;
  localparam int          IM_ADDR_W        = 14;
  localparam int          IM_PARITY_WORD_W = 33;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } im_state_e;

endpackage : im_pkg

// File: rtl/im_sram_bank.sv
// Single-port synchronous word array: one write port and one registered read
// port sharing the address. Width is a parameter so a parity bit can ride along.
// Neither the array nor the read register is reset.
module im_sram_bank #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write on we_i, register the addressed word on re_i (otherwise hold).
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
    if (re_i) rdata_q     <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule : im_sram_bank

// File: rtl/im_responder.sv
// Instruction-memory responder: boot loader port (BOOT) then 1-cycle fetch
// reads (RUN). Returns NOP and asserts im_busy while loading.
// Optional feature macro: IM_PARITY_EN (per-word even parity, im_parity_err).
module im_responder
  import im_pkg::*;
#(
  parameter int DEPTH  = 16384,
  parameter int ADDR_W = IM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] instr_addr,
  input  logic              im_hold,
  output logic [31:0]       IM_data_out,
  output logic              im_busy,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              im_parity_err
);

`ifdef IM_PARITY_EN
  localparam int WORD_W = IM_PARITY_WORD_W;
`else
  localparam int WORD_W = 32;
`endif

  im_state_e         state_q, state_d;
  // 1 when the output register holds a word read from the array, 0 when NOP.
  logic              sel_mem_q, sel_mem_d;
  logic              bank_we, bank_re;
  logic [ADDR_W-1:0] bank_addr;
  logic [WORD_W-1:0] bank_wdata, bank_rdata;

  // State and output-select registers; reset lands in BOOT showing NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BOOT;
      sel_mem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_mem_q <= sel_mem_d;
    end
  end

  // Next state, loader handshake, array port steering and hold handling.
  always_comb begin
    state_d   = state_q;
    sel_mem_d = sel_mem_q;
    ld_ready  = 1'b0;
    im_busy   = 1'b0;
    bank_we   = 1'b0;
    bank_re   = 1'b0;
    bank_addr = instr_addr;
    case (state_q)
      BOOT: begin
        ld_ready  = 1'b1;
        im_busy   = 1'b1;
        bank_addr = ld_addr;
        if (ld_valid) begin
          bank_we = 1'b1;
          if (ld_last) state_d = RUN;
        end
        if (!im_hold) sel_mem_d = 1'b0;
      end
      RUN: begin
        if (!im_hold) begin
          bank_re   = 1'b1;
          sel_mem_d = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

`ifdef IM_PARITY_EN
  assign bank_wdata = {^ld_data, ld_data};
`else
  assign bank_wdata = ld_data;
`endif

  im_sram_bank #(
    .WIDTH  (WORD_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_bank (
    .clk     (clk),
    .addr_i  (bank_addr),
    .we_i    (bank_we),
    .wdata_i (bank_wdata),
    .re_i    (bank_re),
    .rdata_o (bank_rdata)
  );

  assign IM_data_out = sel_mem_q ? bank_rdata[31:0] : IM_NOP;

`ifdef IM_PARITY_EN
  assign im_parity_err = sel_mem_q & ((^bank_rdata[31:0]) ^ bank_rdata[32]);
`else
  assign im_parity_err = 1'b0;
`endif

endmodule : im_responder

// File: tb/tb_im_responder.sv
// Self-checking bench for im_responder: behavioural model compared every
// cycle, plus directed literal checks on the boot/run/hold/reset sequences.
module tb_im_responder;

  localparam int          ADDR_W = 14;
  localparam int          DEPTH  = 16384;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] instr_addr;
  logic              im_hold;
  logic [31:0]       IM_data_out;
  logic              im_busy;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              ld_last;
  logic              im_parity_err;

  im_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_addr    (instr_addr),
    .im_hold       (im_hold),
    .IM_data_out   (IM_data_out),
    .im_busy       (im_busy),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .ld_last       (ld_last),
    .im_parity_err (im_parity_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory contents, boot flag and expected output word.
  logic [31:0] mdl     [DEPTH];
  bit          known   [DEPTH];
  bit          corrupt [DEPTH];
  bit          m_boot  = 1'b1;
  logic [31:0] m_out   = NOP;
  bit          m_known = 1'b1;
  bit          m_perr  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_boot = 1'b1; m_out = NOP; m_known = 1'b1; m_perr = 1'b0;
    end else if (m_boot) begin
      if (ld_valid) begin
        mdl[ld_addr]     = ld_data;
        known[ld_addr]   = 1'b1;
        corrupt[ld_addr] = 1'b0;
        if (ld_last) m_boot = 1'b0;
      end
      if (!im_hold) begin
        m_out = NOP; m_known = 1'b1; m_perr = 1'b0;
      end
    end else if (!im_hold) begin
      m_out   = mdl[instr_addr];
      m_known = known[instr_addr];
      m_perr  = corrupt[instr_addr];
    end
    #1;
    chk("model_busy",  32'(im_busy),  32'(m_boot));
    chk("model_ready", 32'(ld_ready), 32'(m_boot));
    if (m_known) begin
      chk("model_data", IM_data_out, m_out);
      chk("model_perr", 32'(im_parity_err), 32'(m_perr));
    end
  end

  logic [31:0] prog [4];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    prog[0] = 32'h00500093; prog[1] = 32'h00100113;
    prog[2] = 32'h002081B3; prog[3] = 32'h0000006F;
    rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    im_hold = 1'b0; instr_addr = '0;

    // Reset state, then idle in BOOT.
    repeat (2) @(negedge clk);
    chk("rst_data",  IM_data_out, NOP);
    chk("rst_busy",  32'(im_busy), 32'd1);
    chk("rst_ready", 32'(ld_ready), 32'd1);
    chk("rst_perr",  32'(im_parity_err), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_data", IM_data_out, 32'h13);
    chk("idle_busy", 32'(im_busy), 32'd1);

    // Load four words; the last one ends BOOT.
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_addr = ADDR_W'(i); ld_data = prog[i]; ld_last = (i == 3);
      @(negedge clk);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("after_last_busy",  32'(im_busy), 32'd0);
    chk("after_last_ready", 32'(ld_ready), 32'd0);
    chk("after_last_data",  IM_data_out, NOP);

    // Consecutive reads, one cycle latency.
    for (int i = 0; i < 4; i++) begin
      instr_addr = ADDR_W'(i);
      @(negedge clk);
      chk("read_seq", IM_data_out, prog[i]);
    end

    // Hold for three cycles while the address moves.
    instr_addr = 1; @(negedge clk);
    chk("pre_hold", IM_data_out, prog[1]);
    im_hold = 1'b1;
    instr_addr = 2; @(negedge clk); chk("hold1", IM_data_out, prog[1]);
    instr_addr = 3; @(negedge clk); chk("hold2", IM_data_out, prog[1]);
    instr_addr = 0; @(negedge clk); chk("hold3", IM_data_out, prog[1]);
    im_hold = 1'b0;
    instr_addr = 3; @(negedge clk); chk("resume1", IM_data_out, prog[3]);
    instr_addr = 2; @(negedge clk); chk("resume2", IM_data_out, prog[2]);

    // Loader traffic in RUN is ignored.
    ld_valid = 1'b1; ld_addr = 1; ld_data = 32'hDEADBEEF; ld_last = 1'b1; instr_addr = 0;
    repeat (3) @(negedge clk);
    chk("run_ready", 32'(ld_ready), 32'd0);
    ld_valid = 1'b0; ld_last = 1'b0;
    instr_addr = 1; @(negedge clk);
    chk("run_ld_ignored", IM_data_out, prog[1]);

    // Reset from RUN is asynchronous and returns to BOOT.
    rst = 1'b1; #1;
    chk("async_rst_data", IM_data_out, NOP);
    chk("async_rst_busy", 32'(im_busy), 32'd1);
    @(negedge clk); rst = 1'b0;

    // Partial load of two words, interrupted by reset.
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_addr = ADDR_W'(i); ld_data = prog[i]; ld_last = 1'b0;
      @(negedge clk);
    end
    ld_valid = 1'b0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("midload_busy", 32'(im_busy), 32'd1);
    chk("midload_data", IM_data_out, NOP);

    // Reload only address 3 with a different word.
    ld_valid = 1'b1; ld_addr = 3; ld_data = 32'h00C0006F; ld_last = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("reload_busy", 32'(im_busy), 32'd0);
    instr_addr = 0; @(negedge clk); chk("keep0", IM_data_out, 32'h00500093);
    instr_addr = 1; @(negedge clk); chk("keep1", IM_data_out, 32'h00100113);
    instr_addr = 2; @(negedge clk); chk("keep2", IM_data_out, 32'h002081B3);
    instr_addr = 3; @(negedge clk); chk("new3",  IM_data_out, 32'h00C0006F);

`ifdef IM_PARITY_EN
    // Flip one stored data bit at address 2; only that read flags parity.
    dut.u_bank.mem[2][0] = ~dut.u_bank.mem[2][0];
    mdl[2] = mdl[2] ^ 32'h1;
    corrupt[2] = 1'b1;
    instr_addr = 0; @(negedge clk); chk("perr0", 32'(im_parity_err), 32'd0);
    instr_addr = 1; @(negedge clk); chk("perr1", 32'(im_parity_err), 32'd0);
    instr_addr = 2; @(negedge clk); chk("perr2", 32'(im_parity_err), 32'd1);
    chk("perr2_data", IM_data_out, 32'h002081B2);
    instr_addr = 3; @(negedge clk); chk("perr3", 32'(im_parity_err), 32'd0);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_im_responder

// File: doc/im_responder.md
# im_responder

Instruction-memory responder at the far end of the fetch interface: it accepts the word address driven by the fetch stage and returns the 32-bit instruction one cycle later. It also owns the boot path. After reset it sits in a load phase, accepting program words over a valid/ready loader port. While loading it returns NOPs and holds the core in a stall. It sits between the top-level program loader and the fetch stage, in place of a behavioural memory model.

## Interface
- DEPTH, 16384: number of 32-bit words; must equal 2**ADDR_W.
- ADDR_W, 14: word-address width, matching the fetch stage's word address (PC[15:2]).
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr_addr  input  ADDR_W  word address from the fetch stage.
- im_hold  input  1  when 1, the read-data register keeps its value (fetch stall).
- IM_data_out  output  32  registered instruction for the address presented in the previous cycle.
- im_busy  output  1  1 while in BOOT; fetch must treat it as a PC stall.
- ld_valid  input  1  loader word valid.
- ld_ready  output  1  responder accepts a loader word.
- ld_addr  input  ADDR_W  loader word address.
- ld_data  input  32  loader word.
- ld_last  input  1  marks the final loader word.
- im_parity_err  output  1  parity mismatch on the word in IM_data_out (see Configuration).

## Operation
- Two-state FSM: BOOT and RUN. Reset enters BOOT.
- BOOT:
  - ld_ready=1 and im_busy=1.
  - A word is accepted when ld_valid && ld_ready; it is written to mem[ld_addr] on that edge.
  - Accepting a word with ld_last=1 moves the FSM to RUN on the same edge.
  - IM_data_out is forced to NOP (32'h0000_0013) whenever its register updates.
- RUN:
  - ld_ready=0, im_busy=0; loader inputs are ignored.
  - Each edge with im_hold=0 loads IM_data_out from mem[instr_addr].
  - Each edge with im_hold=1 leaves IM_data_out unchanged.
- There is no path from RUN back to BOOT except rst.
- instr_addr is used unmodified. Addresses are always in range because DEPTH=2**ADDR_W, so there is no wrap logic.
- The memory array is not reset. Contents survive a rst pulse, and only words rewritten in the next BOOT change.
- A reset during BOOT discards the remainder of the load. Words already written stay in the array. The loader restarts its transfer.
- im_hold asserted in BOOT: IM_data_out keeps its value, which is still NOP.

## Timing
- Reset values: IM_data_out=32'h0000_0013, im_busy=1, ld_ready=1, im_parity_err=0, state=BOOT.
- Read latency is 1 cycle: address at edge N, data valid after edge N+1.
- The ld_last accept edge is edge N:
  - im_busy and ld_ready fall after edge N.
  - The first real read registers at edge N+1.
  - IM_data_out shows NOP up to and including the cycle after edge N.
- A loader write and a fetch read to the same address cannot occur in one cycle, because writes only happen in BOOT and reads only in RUN. There is no bypass.
- ld_ready is a pure function of state, with no dependence on ld_valid.

## Configuration
- IM_PARITY_EN defined:
  - Each stored word carries one extra even-parity bit, computed on ld_data at write.
  - A read registers im_parity_err = (^data) ^ stored_parity, aligned with IM_data_out and held under im_hold.
  - In BOOT, im_parity_err=0.
- IM_PARITY_EN undefined:
  - The array is 32 bits wide with no parity storage.
  - im_parity_err is tied 0.
  - The port list is identical in both builds.

## Structure
- Shared package im_pkg holds:
  - the NOP constant;
  - the BOOT/RUN state enum;
  - the ADDR_W default;
  - the parity-enabled word-width constant.
- One sub-module, im_sram_bank: a single-port synchronous array with one write port and one registered read port. It is width-parameterised so the parity bit fits inside it.
- The FSM, loader handshake, hold logic and NOP muxing live in im_responder.

## Test plan
- Reset then idle: IM_data_out=32'h13, im_busy=1, ld_ready=1 for 10 cycles with ld_valid=0.
- Load addresses 0..3 with 32'h00500093, 32'h00100113, 32'h002081B3, 32'h0000006F (last=1), then present addresses 0,1,2,3 on consecutive cycles. Required: the same four words appear one cycle later each, and im_busy=0 from the cycle after the last accept.
- im_hold=1 for 3 cycles while instr_addr changes: IM_data_out stays at the prior word, then resumes with a 1-cycle latency.
- rst pulsed mid-load after 2 of 4 words: FSM returns to BOOT with NOP output. After a reload of only address 3, addresses 0–1 read their original values.
- ld_valid held with ld_last in RUN: no write, and a subsequent read returns the old word.
- IM_PARITY_EN only: force-flip one stored bit at address 2 and read it. Required: im_parity_err=1 in the same cycle as the data, and 0 for addresses 0, 1 and 3.
